// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stop/enable levels, stall
// vector encodings, FSM state type and the stall priority encoder.
package pipe_ctrl_pkg;

  localparam logic STOP     = 1'b1;
  localparam logic NOT_STOP = 1'b0;
  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;

  // Stall vector bit order: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
  localparam logic [5:0] STALL_NONE = {6{NOT_STOP}};
  localparam logic [5:0] STALL_IF   = {{4{NOT_STOP}}, {2{STOP}}};
  localparam logic [5:0] STALL_ID   = {{3{NOT_STOP}}, {3{STOP}}};
  localparam logic [5:0] STALL_EX   = {{2{NOT_STOP}}, {4{STOP}}};
  localparam logic [5:0] STALL_MEM  = {NOT_STOP, {5{STOP}}};

  typedef enum logic {
    PCTRL_RUN   = 1'b0,
    PCTRL_FLUSH = 1'b1
  } pctrl_state_e;

  // Highest-priority request wins; later stages stall everything upstream.
  function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                               input logic req_ex, input logic req_mem);
    logic [5:0] v;
    if (req_mem)     v = STALL_MEM;
    else if (req_ex) v = STALL_EX;
    else if (req_id) v = STALL_ID;
    else if (req_if) v = STALL_IF;
    else             v = STALL_NONE;
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles with a
// sticky error flag that sets when the count reaches MAX.
module stall_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic err
);

  localparam int unsigned CW   = (MAX > 1) ? $clog2(MAX + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX);

  logic [CW-1:0] cnt;

  // Count stalled cycles, saturate at MAX, latch the error on reaching it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      err <= DISABLE;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (cnt != CMAX) cnt <= cnt + 1'b1;
      if (cnt >= CMAX - 1'b1) err <= ENABLE;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: stall priority encoder, exception flush FSM
// and stall watchdog. Optional PIPE_CTRL_PERF_EN adds perf_stall_cnt.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned WDOG_MAX     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_req,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        busy_flush,
  output logic        wdog_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  pctrl_state_e  state, state_n;
  logic [FW-1:0] cnt, cnt_n;
  logic          flush_n;
  logic [31:0]   new_pc_n;
  logic          wdog_inc;

  // FSM state, flush hold counter and registered redirect outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= PCTRL_RUN;
      cnt    <= '0;
      flush  <= DISABLE;
      new_pc <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      flush  <= flush_n;
      new_pc <= new_pc_n;
    end
  end

  // Next-state logic and the combinational stall vector.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    flush_n  = flush;
    new_pc_n = new_pc;
    stall    = STALL_NONE;
    case (state)
      PCTRL_RUN: begin
        if (excp_req) begin
          state_n  = PCTRL_FLUSH;
          cnt_n    = FLUSH_LAST;
          flush_n  = ENABLE;
          new_pc_n = excp_pc;
        end else begin
          stall = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        end
      end
      PCTRL_FLUSH: begin
        if (cnt == '0) begin
          state_n  = PCTRL_RUN;
          flush_n  = DISABLE;
          new_pc_n = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = PCTRL_RUN;
    endcase
    if (reset) stall = STALL_NONE;
  end

  assign busy_flush = (state == PCTRL_FLUSH);
  assign wdog_inc   = (state == PCTRL_RUN) && (stall != STALL_NONE);

  stall_wdog #(
    .MAX (WDOG_MAX)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .inc   (wdog_inc),
    .clr   (!wdog_inc),
    .err   (wdog_err)
  );

`ifdef PIPE_CTRL_PERF_EN
  // Saturating count of cycles in which the PC stage is stopped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
    end else if (stall[0] == STOP && perf_stall_cnt != '1) begin
      perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: instance A (FLUSH_CYCLES=1, WDOG_MAX=4)
// and instance B (FLUSH_CYCLES=3, WDOG_MAX=255) share all inputs.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic        sr_if, sr_id, sr_ex, sr_mem, excp_req;
  logic [31:0] excp_pc;

  logic [5:0]  a_stall, b_stall;
  logic        a_flush, b_flush, a_busy, b_busy, a_wdog, b_wdog;
  logic [31:0] a_npc, b_npc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] a_perf, b_perf;
`endif

  logic [40:0] obs_a, obs_b;
  assign obs_a = {a_stall, a_flush, a_busy, a_wdog, a_npc};
  assign obs_b = {b_stall, b_flush, b_busy, b_wdog, b_npc};

  typedef struct packed {
    logic [3:0]  req;   // {mem, ex, id, if}
    logic        excp;
    logic [31:0] pc;
    logic [40:0] exp;
  } row_t;

  logic [40:0] sb[$];
  int checks = 0;
  int fails  = 0;

  pipe_ctrl #(.FLUSH_CYCLES(1), .WDOG_MAX(4)) dut_a (
    .clk(clk), .reset(reset), .stallreq_if(sr_if), .stallreq_id(sr_id),
    .stallreq_ex(sr_ex), .stallreq_mem(sr_mem), .excp_req(excp_req), .excp_pc(excp_pc),
    .stall(a_stall), .flush(a_flush), .new_pc(a_npc), .busy_flush(a_busy), .wdog_err(a_wdog)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(a_perf)
`endif
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .WDOG_MAX(255)) dut_b (
    .clk(clk), .reset(reset), .stallreq_if(sr_if), .stallreq_id(sr_id),
    .stallreq_ex(sr_ex), .stallreq_mem(sr_mem), .excp_req(excp_req), .excp_pc(excp_pc),
    .stall(b_stall), .flush(b_flush), .new_pc(b_npc), .busy_flush(b_busy), .wdog_err(b_wdog)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_stall_cnt(b_perf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [40:0] mk(input logic [5:0] s, input logic f, input logic b,
                                     input logic w, input logic [31:0] p);
    return {s, f, b, w, p};
  endfunction

  function automatic row_t rw(input logic [3:0] req, input logic ex, input logic [31:0] pc,
                              input logic [40:0] e);
    row_t r;
    r.req = req; r.excp = ex; r.pc = pc; r.exp = e;
    return r;
  endfunction

  task automatic apply(input row_t r);
    {sr_mem, sr_ex, sr_id, sr_if} = r.req;
    excp_req = r.excp;
    excp_pc  = r.pc;
  endtask

  task automatic test_reset();
    logic [40:0] e;
    #3;
    sb.push_back(mk(6'b0, 0, 0, 0, 32'h0));
    sb.push_back(mk(6'b0, 0, 0, 0, 32'h0));
    e = sb.pop_front(); checks++;
    if (obs_a !== e) begin fails++; $display("FAIL reset_a got %h want %h", obs_a, e); end
    e = sb.pop_front(); checks++;
    if (obs_b !== e) begin fails++; $display("FAIL reset_b got %h want %h", obs_b, e); end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (a_perf !== 32'h0) begin fails++; $display("FAIL reset_perf got %h want 0", a_perf); end
`endif
    @(negedge clk); reset = 1'b0;
    sb.push_back(mk(6'b0, 0, 0, 0, 32'h0));
    #2;
    e = sb.pop_front(); checks++;
    if (obs_a !== e) begin fails++; $display("FAIL reset_release got %h want %h", obs_a, e); end
  endtask

  task automatic test_id_stall();
    row_t rows[$];
    logic [40:0] e;
    for (int k = 0; k < 3; k++) rows.push_back(rw(4'b0010, 0, 0, mk(6'b000111, 0, 0, 0, 0)));
    for (int k = 0; k < 2; k++) rows.push_back(rw(4'b0000, 0, 0, mk(6'b000000, 0, 0, 0, 0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); apply(rows[i]); sb.push_back(rows[i].exp); #2;
      e = sb.pop_front(); checks++;
      if (obs_a !== e) begin fails++; $display("FAIL id_stall[%0d] got %h want %h", i, obs_a, e); end
    end
  endtask

  task automatic test_priority();
    row_t rows[$];
    logic [40:0] e;
    rows.push_back(rw(4'b1001, 0, 0, mk(6'b011111, 0, 0, 0, 0)));
    rows.push_back(rw(4'b0001, 0, 0, mk(6'b000011, 0, 0, 0, 0)));
    rows.push_back(rw(4'b0110, 0, 0, mk(6'b001111, 0, 0, 0, 0)));
    rows.push_back(rw(4'b0000, 0, 0, mk(6'b000000, 0, 0, 0, 0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); apply(rows[i]); sb.push_back(rows[i].exp); #2;
      e = sb.pop_front(); checks++;
      if (obs_a !== e) begin fails++; $display("FAIL priority[%0d] got %h want %h", i, obs_a, e); end
    end
  endtask

  task automatic test_excp();
    row_t rows[$];
    logic [40:0] e;
    rows.push_back(rw(4'b0100, 1, 32'h180, mk(6'b0, 0, 0, 0, 32'h0)));
    rows.push_back(rw(4'b0100, 0, 32'h0,   mk(6'b0, 1, 1, 0, 32'h180)));
    for (int k = 0; k < 4; k++) rows.push_back(rw(4'b0000, 0, 0, mk(6'b0, 0, 0, 0, 32'h0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); apply(rows[i]); sb.push_back(rows[i].exp); #2;
      e = sb.pop_front(); checks++;
      if (obs_a !== e) begin fails++; $display("FAIL excp[%0d] got %h want %h", i, obs_a, e); end
    end
  endtask

  task automatic test_flush_multi();
    row_t rows[$];
    logic [40:0] e;
    rows.push_back(rw(4'b1000, 1, 32'h180, mk(6'b0, 0, 0, 0, 32'h0)));
    rows.push_back(rw(4'b1000, 1, 32'h200, mk(6'b0, 1, 1, 0, 32'h180)));
    rows.push_back(rw(4'b1000, 0, 32'h0,   mk(6'b0, 1, 1, 0, 32'h180)));
    rows.push_back(rw(4'b1000, 0, 32'h0,   mk(6'b0, 1, 1, 0, 32'h180)));
    rows.push_back(rw(4'b1000, 0, 32'h0,   mk(6'b011111, 0, 0, 0, 32'h0)));
    rows.push_back(rw(4'b0000, 0, 32'h0,   mk(6'b0, 0, 0, 0, 32'h0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); apply(rows[i]); sb.push_back(rows[i].exp); #2;
      e = sb.pop_front(); checks++;
      if (obs_b !== e) begin fails++; $display("FAIL flush_multi[%0d] got %h want %h", i, obs_b, e); end
    end
  endtask

  task automatic test_wdog();
    row_t rows[$];
    logic [40:0] e;
    for (int k = 0; k < 3; k++) rows.push_back(rw(4'b0100, 0, 0, mk(6'b001111, 0, 0, 0, 0)));
    rows.push_back(rw(4'b0000, 0, 0, mk(6'b0, 0, 0, 0, 0)));
    for (int k = 0; k < 4; k++) rows.push_back(rw(4'b0100, 0, 0, mk(6'b001111, 0, 0, 0, 0)));
    rows.push_back(rw(4'b0000, 0, 0, mk(6'b0, 0, 0, 1, 0)));
    rows.push_back(rw(4'b0000, 0, 0, mk(6'b0, 0, 0, 1, 0)));
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk); apply(rows[i]); sb.push_back(rows[i].exp); #2;
      e = sb.pop_front(); checks++;
      if (obs_a !== e) begin fails++; $display("FAIL wdog[%0d] got %h want %h", i, obs_a, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [40:0] e;
    @(negedge clk); apply(rw(4'b0000, 1, 32'habc, 0));
    sb.push_back(mk(6'b0, 0, 0, 1, 32'h0));
    #2;
    e = sb.pop_front(); checks++;
    if (obs_a !== e) begin fails++; $display("FAIL arst_pre_a got %h want %h", obs_a, e); end
    @(negedge clk); apply(rw(4'b0000, 0, 32'h0, 0));
    sb.push_back(mk(6'b0, 1, 1, 0, 32'habc));
    #2;
    e = sb.pop_front(); checks++;
    if (obs_b !== e) begin fails++; $display("FAIL arst_flushing_b got %h want %h", obs_b, e); end
    #1 reset = 1'b1;
    #1;
    sb.push_back(mk(6'b0, 0, 0, 0, 32'h0));
    sb.push_back(mk(6'b0, 0, 0, 0, 32'h0));
    e = sb.pop_front(); checks++;
    if (obs_a !== e) begin fails++; $display("FAIL arst_a got %h want %h", obs_a, e); end
    e = sb.pop_front(); checks++;
    if (obs_b !== e) begin fails++; $display("FAIL arst_b got %h want %h", obs_b, e); end
`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (a_perf !== 32'h0) begin fails++; $display("FAIL arst_perf got %h want 0", a_perf); end
`endif
    @(negedge clk); reset = 1'b0;
    sb.push_back(mk(6'b0, 0, 0, 0, 32'h0));
    #2;
    e = sb.pop_front(); checks++;
    if (obs_b !== e) begin fails++; $display("FAIL arst_release_b got %h want %h", obs_b, e); end
  endtask

  initial begin
    reset = 1'b1;
    sr_if = 1'b0; sr_id = 1'b0; sr_ex = 1'b0; sr_mem = 1'b0;
    excp_req = 1'b0; excp_pc = 32'h0;
    test_reset();
    test_id_stall();
    test_priority();
    test_excp();
    test_flush_multi();
    test_wdog();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
